// File: rtl/div_sequencer_if.sv
// ============================================================================
// Module      : div_sequencer_if
// Description : Bundle between the ID stage / PC logic and the divide
//               sequencer. The master side presents the decoded instruction
//               and PC pair; the slave side (div_sequencer) returns the
//               divider start, stall, HiLo write and resume controls plus
//               the captured PC pair.
//               Optional macro DIV_ZERO_TRAP_EN adds divisor_zero (master
//               to slave) and div_trap (slave to master).
// Ports       : instr_in, issue_valid, preJump, pc_in, pc_next_in  (to seq)
//               div_start, div_busy, stall_out, hilo_we, resume,
//               pc_hold, pc_next_hold                              (from seq)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_sequencer_if;
    logic [31:0] instr_in;
    logic        issue_valid;
    logic        preJump;
    logic [31:0] pc_in;
    logic [31:0] pc_next_in;
    logic        div_start;
    logic        div_busy;
    logic        stall_out;
    logic        hilo_we;
    logic        resume;
    logic [31:0] pc_hold;
    logic [31:0] pc_next_hold;
`ifdef DIV_ZERO_TRAP_EN
    logic        divisor_zero;
    logic        div_trap;
`endif

    modport master (
        output instr_in, issue_valid, preJump, pc_in, pc_next_in,
`ifdef DIV_ZERO_TRAP_EN
        output divisor_zero,
        input  div_trap,
`endif
        input  div_start, div_busy, stall_out, hilo_we, resume,
        input  pc_hold, pc_next_hold
    );

    modport slave (
        input  instr_in, issue_valid, preJump, pc_in, pc_next_in,
`ifdef DIV_ZERO_TRAP_EN
        input  divisor_zero,
        output div_trap,
`endif
        output div_start, div_busy, stall_out, hilo_we, resume,
        output pc_hold, pc_next_hold
    );
endinterface

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// Module      : div_sequencer
// Description : Sequences the multi-cycle divider from the ID stage. A DIV
//               in ID (IDLE state) fires a one-cycle div_start, stalls the
//               front end for DIV_CYCLES+1 cycles while the PC pair is held,
//               then pulses hilo_we and resume together for one cycle.
//               Optional macro DIV_ZERO_TRAP_EN: a DIV with divisor_zero set
//               raises div_trap for one cycle instead of starting.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - div_sequencer_if.slave (instruction/PC in,
//                        divider/stall/HiLo/resume controls and PC hold out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_sequencer #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter logic [5:0]  FUNCT_DIV  = 6'd27,
    parameter int unsigned CNT_W      = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    div_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       pc_hold_q, pc_hold_d;
    logic [31:0]       pc_next_hold_q, pc_next_hold_d;

    logic              is_div;
    logic              zero_trap;
    logic              div_start_c;
    logic              div_busy_c;
    logic              stall_c;
    logic              wb_c;

    // Only opcode and funct identify DIV; the register fields are the
    // datapath's concern.
    logic [19:0]       unused_instr_bits;
    assign unused_instr_bits = bus.instr_in[25:6];

    // rst_n gates issue so no pulse can leak out while reset is held.
    assign is_div = rst_n && bus.issue_valid && !bus.preJump
                 && (bus.instr_in[31:26] == 6'd0)
                 && (bus.instr_in[5:0] == FUNCT_DIV);

`ifdef DIV_ZERO_TRAP_EN
    assign zero_trap    = is_div && bus.divisor_zero;
    assign bus.div_trap = (state_q == S_IDLE) && zero_trap;
`else
    assign zero_trap    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            pc_hold_q      <= '0;
            pc_next_hold_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pc_hold_q      <= pc_hold_d;
            pc_next_hold_q <= pc_next_hold_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_hold_d      = pc_hold_q;
        pc_next_hold_d = pc_next_hold_q;
        div_start_c    = 1'b0;
        div_busy_c     = 1'b0;
        stall_c        = 1'b0;
        wb_c           = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A trapped divide-by-zero leaves the pipeline untouched.
                if (is_div && !zero_trap) begin
                    div_start_c    = 1'b1;
                    stall_c        = 1'b1;
                    pc_hold_d      = bus.pc_in;
                    pc_next_hold_d = bus.pc_next_in;
                    cnt_d          = '0;
                    state_d        = S_RUN;
                end
            end
            S_RUN: begin
                stall_c    = 1'b1;
                div_busy_c = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                // The same DIV still sits in ID, so is_div is not looked at
                // here; the front end resumes on the next cycle.
                div_busy_c = 1'b1;
                wb_c       = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.div_start    = div_start_c;
    assign bus.div_busy     = div_busy_c;
    assign bus.stall_out    = stall_c;
    assign bus.hilo_we      = wb_c;
    assign bus.resume       = wb_c;
    assign bus.pc_hold      = pc_hold_q;
    assign bus.pc_next_hold = pc_next_hold_q;

`ifndef SYNTHESIS
    a_cnt_fits : assert property (@(posedge clk) disable iff (!rst_n)
        (2 ** CNT_W) > DIV_CYCLES);
    a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= LAST_CNT);
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// ============================================================================
// Module      : tb_div_sequencer
// Description : Self-checking bench for div_sequencer. A cycle-level model
//               tracks the issue cycle of the last accepted DIV and derives
//               the RUN window and WB cycle from it arithmetically.
//               Honours DIV_ZERO_TRAP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_div_sequencer;

    localparam int          D         = 32;
    localparam logic [31:0] DIV_INSTR = 32'h0085001B;
    localparam logic [31:0] ADD_INSTR = 32'h00851020;
`ifdef DIV_ZERO_TRAP_EN
    localparam bit          TRAP_EN   = 1'b1;
`else
    localparam bit          TRAP_EN   = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_sequencer_if bus ();

    div_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: absolute cycle of the last issue and captured PCs.
    int          m_issue = -1000;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_pcn   = '0;

    // Control vector: {start, busy, stall, hilo_we, resume, trap}
    logic [5:0]  exp_ctrl;
    logic [63:0] exp_pc;
    logic [5:0]  act_ctrl;
    logic [63:0] act_pc;

    always_comb begin
        act_ctrl = {bus.div_start, bus.div_busy, bus.stall_out,
                    bus.hilo_we, bus.resume, 1'b0};
`ifdef DIV_ZERO_TRAP_EN
        act_ctrl[0] = bus.div_trap;
`endif
        act_pc = {bus.pc_hold, bus.pc_next_hold};
    end

    function automatic logic [31:0] rand_div();
        logic [31:0] r;
        r        = $urandom;
        r[31:26] = 6'd0;
        r[5:0]   = 6'd27;
        return r;
    endfunction

    function automatic logic [31:0] rand_other();
        logic [31:0] r;
        r = $urandom;
        if (r[31:26] == 6'd0 && r[5:0] == 6'd27) r[0] = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        m_issue = -1000;
        m_pc    = '0;
        m_pcn   = '0;
    endtask

    // Apply one cycle of inputs after the rising edge, move to the falling
    // edge and compute what the outputs must be in this cycle.
    task automatic drive_cycle(input logic [31:0] ins, input logic iv,
                               input logic pj, input logic [31:0] pc,
                               input logic [31:0] pcn, input logic dz);
        logic dec;
        @(posedge clk);
        #1;
        bus.instr_in    = ins;
        bus.issue_valid = iv;
        bus.preJump     = pj;
        bus.pc_in       = pc;
        bus.pc_next_in  = pcn;
`ifdef DIV_ZERO_TRAP_EN
        bus.divisor_zero = dz;
`endif
        cyc++;
        @(negedge clk);
        dec      = iv && !pj && (ins[31:26] == 6'd0) && (ins[5:0] == 6'd27);
        exp_pc   = {m_pc, m_pcn};
        exp_ctrl = '0;
        if (cyc > m_issue && cyc <= m_issue + D) begin
            exp_ctrl[4] = 1'b1;
            exp_ctrl[3] = 1'b1;
        end else if (cyc == m_issue + D + 1) begin
            exp_ctrl[4] = 1'b1;
            exp_ctrl[2] = 1'b1;
            exp_ctrl[1] = 1'b1;
        end else if (dec && dz && TRAP_EN) begin
            exp_ctrl[0] = 1'b1;
        end else if (dec) begin
            exp_ctrl[5] = 1'b1;
            exp_ctrl[3] = 1'b1;
            m_issue     = cyc;
            m_pc        = pc;
            m_pcn       = pcn;
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus.instr_in     = ADD_INSTR;
        bus.issue_valid  = 1'b0;
        bus.preJump      = 1'b0;
        bus.pc_in        = 32'h1234;
        bus.pc_next_in   = 32'h1238;
`ifdef DIV_ZERO_TRAP_EN
        bus.divisor_zero = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        total++;
        if (act_ctrl !== 6'd0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=%b", act_ctrl, 6'd0);
        end
        total++;
        if (act_pc !== 64'd0) begin
            bad++;
            $display("FAIL reset_pc got=%h exp=%h", act_pc, 64'd0);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(ADD_INSTR, 1'b1, 1'b0, $urandom, $urandom, 1'b0);
            total++;
            if (act_ctrl !== exp_ctrl) begin
                bad++;
                $display("FAIL idle_ctrl cyc=%0d got=%b exp=%b", cyc, act_ctrl, exp_ctrl);
            end
            total++;
            if (act_pc !== exp_pc) begin
                bad++;
                $display("FAIL idle_pc cyc=%0d got=%h exp=%h", cyc, act_pc, exp_pc);
            end
        end
    endtask

    task automatic test_single_div();
        int t;
        int hilo_n;
        int hilo_at;
        int stall_n;
        hilo_n  = 0;
        hilo_at = -1;
        stall_n = 0;
        for (int i = 0; i < 4; i++)
            drive_cycle(ADD_INSTR, 1'b1, 1'b0, 32'h30, 32'h34, 1'b0);
        t = cyc + 1;
        for (int i = 0; i < D + 3; i++) begin
            if (i <= D + 1)
                drive_cycle(DIV_INSTR, 1'b1, 1'b0, 32'h40, 32'h44, 1'b0);
            else
                drive_cycle(ADD_INSTR, 1'b1, 1'b0, 32'h48, 32'h4C, 1'b0);
            if (bus.hilo_we === 1'b1) begin
                hilo_n++;
                hilo_at = cyc;
            end
            if (bus.stall_out === 1'b1) stall_n++;
            total++;
            if (act_ctrl !== exp_ctrl) begin
                bad++;
                $display("FAIL single_ctrl cyc=%0d got=%b exp=%b", cyc, act_ctrl, exp_ctrl);
            end
            total++;
            if (act_pc !== exp_pc) begin
                bad++;
                $display("FAIL single_pc cyc=%0d got=%h exp=%h", cyc, act_pc, exp_pc);
            end
        end
        total++;
        if (hilo_n !== 1 || hilo_at !== t + D + 1) begin
            bad++;
            $display("FAIL single_latency got=%0d pulses at %0d exp=1 at %0d", hilo_n, hilo_at, t + D + 1);
        end
        total++;
        if (stall_n !== D + 1) begin
            bad++;
            $display("FAIL single_stall_len got=%0d exp=%0d", stall_n, D + 1);
        end
        total++;
        if (act_pc !== {32'h40, 32'h44}) begin
            bad++;
            $display("FAIL single_hold got=%h exp=%h", act_pc, {32'h40, 32'h44});
        end
    endtask

    task automatic test_prejump();
        int t;
        int hilo_at;
        hilo_at = -1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(rand_div(), 1'b1, 1'b1, $urandom, $urandom, 1'b0);
            total++;
            if (act_ctrl !== exp_ctrl) begin
                bad++;
                $display("FAIL flush_ctrl cyc=%0d got=%b exp=%b", cyc, act_ctrl, exp_ctrl);
            end
        end
        t = cyc + 1;
        for (int i = 0; i < D + 3; i++) begin
            if (i == 0)
                drive_cycle(DIV_INSTR, 1'b1, 1'b0, $urandom, $urandom, 1'b0);
            else if (i <= D + 1)
                drive_cycle(DIV_INSTR, 1'b1, 1'b1, $urandom, $urandom, 1'b0);
            else
                drive_cycle(ADD_INSTR, 1'b1, 1'b0, $urandom, $urandom, 1'b0);
            if (bus.hilo_we === 1'b1) hilo_at = cyc;
            total++;
            if (act_ctrl !== exp_ctrl) begin
                bad++;
                $display("FAIL prejump_ctrl cyc=%0d got=%b exp=%b", cyc, act_ctrl, exp_ctrl);
            end
            total++;
            if (act_pc !== exp_pc) begin
                bad++;
                $display("FAIL prejump_pc cyc=%0d got=%h exp=%h", cyc, act_pc, exp_pc);
            end
        end
        total++;
        if (hilo_at !== t + D + 1) begin
            bad++;
            $display("FAIL prejump_latency got=%0d exp=%0d", hilo_at, t + D + 1);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int hilo_n;
        int second_start;
        hilo_n       = 0;
        second_start = -1;
        t            = cyc + 1;
        for (int i = 0; i < 2 * (D + 2) + 1; i++) begin
            if (i < 2 * (D + 2))
                drive_cycle(DIV_INSTR, 1'b1, 1'b0, $urandom, $urandom, 1'b0);
            else
                drive_cycle(ADD_INSTR, 1'b1, 1'b0, $urandom, $urandom, 1'b0);
            if (bus.hilo_we === 1'b1) hilo_n++;
            if (bus.div_start === 1'b1 && cyc != t) second_start = cyc;
            total++;
            if (act_ctrl !== exp_ctrl) begin
                bad++;
                $display("FAIL b2b_ctrl cyc=%0d got=%b exp=%b", cyc, act_ctrl, exp_ctrl);
            end
            total++;
            if (act_pc !== exp_pc) begin
                bad++;
                $display("FAIL b2b_pc cyc=%0d got=%h exp=%h", cyc, act_pc, exp_pc);
            end
        end
        total++;
        if (hilo_n !== 2) begin
            bad++;
            $display("FAIL b2b_hilo_count got=%0d exp=2", hilo_n);
        end
        total++;
        if (second_start !== t + D + 2) begin
            bad++;
            $display("FAIL b2b_second_start got=%0d exp=%0d", second_start, t + D + 2);
        end
    endtask

    task automatic test_reset_mid_run();
        int hilo_n;
        int stall_n;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(DIV_INSTR, 1'b1, 1'b0, $urandom, $urandom, 1'b0);
            total++;
            if (act_ctrl !== exp_ctrl) begin
                bad++;
                $display("FAIL rstrun_pre_ctrl cyc=%0d got=%b exp=%b", cyc, act_ctrl, exp_ctrl);
            end
        end
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.instr_in = ADD_INSTR;
        cyc++;
        @(negedge clk);
        total++;
        if (act_ctrl !== 6'd0) begin
            bad++;
            $display("FAIL rstrun_ctrl got=%b exp=%b", act_ctrl, 6'd0);
        end
        total++;
        if (act_pc !== 64'd0) begin
            bad++;
            $display("FAIL rstrun_pc got=%h exp=%h", act_pc, 64'd0);
        end
        rst_n = 1'b1;
        model_reset();
        hilo_n = 0;
        for (int i = 0; i < 40; i++) begin
            drive_cycle(rand_other(), 1'b1, 1'b0, $urandom, $urandom, 1'b0);
            if (bus.hilo_we === 1'b1 || bus.resume === 1'b1) hilo_n++;
            total++;
            if (act_ctrl !== exp_ctrl) begin
                bad++;
                $display("FAIL rstrun_idle_ctrl cyc=%0d got=%b exp=%b", cyc, act_ctrl, exp_ctrl);
            end
        end
        total++;
        if (hilo_n !== 0) begin
            bad++;
            $display("FAIL rstrun_aborted_wb got=%0d exp=0", hilo_n);
        end
        stall_n = 0;
        for (int i = 0; i < D + 3; i++) begin
            if (i <= D + 1)
                drive_cycle(DIV_INSTR, 1'b1, 1'b0, 32'h80, 32'h84, 1'b0);
            else
                drive_cycle(ADD_INSTR, 1'b1, 1'b0, 32'h88, 32'h8C, 1'b0);
            if (bus.stall_out === 1'b1) stall_n++;
            total++;
            if (act_ctrl !== exp_ctrl) begin
                bad++;
                $display("FAIL rstrun_new_ctrl cyc=%0d got=%b exp=%b", cyc, act_ctrl, exp_ctrl);
            end
            total++;
            if (act_pc !== exp_pc) begin
                bad++;
                $display("FAIL rstrun_new_pc cyc=%0d got=%h exp=%h", cyc, act_pc, exp_pc);
            end
        end
        total++;
        if (stall_n !== D + 1) begin
            bad++;
            $display("FAIL rstrun_stall_len got=%0d exp=%0d", stall_n, D + 1);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int i = 0; i < 500; i++) begin
            ins = ($urandom_range(0, 1) == 1) ? rand_div() : rand_other();
            drive_cycle(ins, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                        $urandom, $urandom, $urandom_range(0, 7) == 0);
            total++;
            if (act_ctrl !== exp_ctrl) begin
                bad++;
                $display("FAIL random_ctrl cyc=%0d got=%b exp=%b", cyc, act_ctrl, exp_ctrl);
            end
            total++;
            if (act_pc !== exp_pc) begin
                bad++;
                $display("FAIL random_pc cyc=%0d got=%h exp=%h", cyc, act_pc, exp_pc);
            end
        end
        // Drain any divide still in flight.
        for (int i = 0; i < D + 2; i++)
            drive_cycle(ADD_INSTR, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

`ifdef DIV_ZERO_TRAP_EN
    task automatic test_div_zero_trap();
        int hilo_n;
        drive_cycle(DIV_INSTR, 1'b1, 1'b0, 32'h100, 32'h104, 1'b1);
        total++;
        if (act_ctrl !== 6'b000001 || act_ctrl !== exp_ctrl) begin
            bad++;
            $display("FAIL trap_pulse got=%b exp=%b", act_ctrl, 6'b000001);
        end
        drive_cycle(ADD_INSTR, 1'b1, 1'b0, 32'h108, 32'h10C, 1'b0);
        total++;
        if (act_ctrl !== exp_ctrl) begin
            bad++;
            $display("FAIL trap_after got=%b exp=%b", act_ctrl, exp_ctrl);
        end
        hilo_n = 0;
        for (int i = 0; i < D + 3; i++) begin
            if (i <= D + 1)
                drive_cycle(DIV_INSTR, 1'b1, 1'b0, 32'h40, 32'h44, 1'b0);
            else
                drive_cycle(ADD_INSTR, 1'b1, 1'b0, 32'h48, 32'h4C, 1'b0);
            if (bus.hilo_we === 1'b1) hilo_n++;
            total++;
            if (act_ctrl !== exp_ctrl) begin
                bad++;
                $display("FAIL trap_normal_ctrl cyc=%0d got=%b exp=%b", cyc, act_ctrl, exp_ctrl);
            end
        end
        total++;
        if (hilo_n !== 1) begin
            bad++;
            $display("FAIL trap_normal_hilo got=%0d exp=1", hilo_n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_div();
        test_prejump();
        test_back_to_back();
        test_reset_mid_run();
`ifdef DIV_ZERO_TRAP_EN
        test_div_zero_trap();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
